// File: rtl/fpll_reconfig_pkg.sv
// Shared constants, FSM state encoding and RMW table entry type for the fPLL reconfig master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpll_reconfig_pkg;

   // Arbitration register: request/release the reconfig bus from PreSICE.
   localparam logic [9:0]  ARB_ADDR     = 10'h000;
   localparam logic [31:0] ARB_REQ_VAL  = 32'h0000_0002;
   localparam logic [31:0] ARB_REL_VAL  = 32'h0000_0001;

   // Calibration register and the bit that kicks off fPLL recalibration.
   localparam logic [9:0]  CAL_ADDR     = 10'h100;
   localparam logic [31:0] CAL_BIT_MASK = 32'h0000_0002;

   // Base of the per-profile register window; each profile owns a 32-byte slot.
   localparam logic [9:0]  PROFILE_BASE = 10'h040;

   typedef enum logic [3:0] {
      IDLE,
      BUS_REQ,
      RD,
      WR,
      CAL_RD,
      CAL_WR,
      BUS_REL,
      SETTLE,
      WAIT_LOCK,
      DONE
   } state_t;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] mask;
      logic [31:0] value;
   } rmw_entry_t;

endpackage

// File: rtl/fpll_profile_rom.sv
// Per-rate-profile RMW table: (profile, index) -> {addr, mask, value}.
// Latency: combinational.
// Backpressure: none.
// Ports: profile[1:0] selects the TMDS rate profile, index selects the entry,
//        entry returns the register address, field mask and field value.
module fpll_profile_rom
   import fpll_reconfig_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic [1:0]       profile,
   input  logic [IDX_W-1:0] index,
   output rmw_entry_t       entry
);

   logic [31:0] profile_word;

   // Each profile is a 32-bit settings word; entry i updates nibble i of
   // register (base + 32*profile + 4*i). With up to 8 entries the profile
   // windows stay disjoint and clear of the calibration register.
   always_comb begin
      profile_word = 32'h0;
      case (profile)
         2'd0:    profile_word = 32'h1357_9BDF;
         2'd1:    profile_word = 32'h2468_ACE0;
         2'd2:    profile_word = 32'h0F1E_2D3C;
         2'd3:    profile_word = 32'h8421_8421;
         default: profile_word = 32'h0;
      endcase
      entry.addr  = PROFILE_BASE + (10'(profile) << 5) + (10'(index) << 2);
      entry.mask  = 32'h0000_000F << {index, 2'b00};
      entry.value = profile_word;
   end

endmodule

// File: rtl/fpll_reconfig_ctrl.sv
// Avalon-MM master that retunes the HDMI TX fPLL to a rate profile, recalibrates it and waits for lock.
// Latency: one cycle per bus transfer with no waitrequest (2*NUM_ENTRIES+4 transfers), then SETTLE_CYCLES+1 to done.
// Backpressure: every command is held stable until reconfig_waitrequest drops; start is ignored while busy.
// Ports: start/rate_sel request a run; busy/done/error report status; reconfig_* is the
//        Avalon-MM master; pll_cal_busy/pll_locked are watched after bus release.
module fpll_reconfig_ctrl
   import fpll_reconfig_pkg::*;
#(
   parameter int NUM_ENTRIES   = 8,
   parameter int LOCK_TIMEOUT  = 1_000_000,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic        reconfig_clk,
   input  logic        reconfig_reset,
   input  logic        start,
   input  logic [1:0]  rate_sel,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        reconfig_write,
   output logic        reconfig_read,
   output logic [9:0]  reconfig_address,
   output logic [31:0] reconfig_writedata,
   input  logic [31:0] reconfig_readdata,
   input  logic        reconfig_waitrequest,
   input  logic        pll_cal_busy,
   input  logic        pll_locked
);

   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int TMR_W = $clog2(LOCK_TIMEOUT + SETTLE_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_ENTRIES - 1);
   localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [1:0]       prof_q, prof_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             write_q, write_d;
   logic             read_q, read_d;
   logic [9:0]       addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             xfer_done;
   rmw_entry_t       entry;

   // The ROM is addressed with next-state profile/index so the bus
   // command for the next transfer can be registered with no bubble.
   fpll_profile_rom #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .IDX_W       (IDX_W)
   ) u_rom (
      .profile (prof_d),
      .index   (idx_d),
      .entry   (entry)
   );

   assign xfer_done = (write_q | read_q) & ~reconfig_waitrequest;

   always_comb begin
      state_d = state_q;
      prof_d  = prof_q;
      idx_d   = idx_q;
      rdata_d = rdata_q;
      timer_d = timer_q;
      error_d = error_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               prof_d  = rate_sel;
               error_d = 1'b0;
               idx_d   = '0;
               timer_d = '0;
               state_d = BUS_REQ;
            end
         end
         BUS_REQ: if (xfer_done) state_d = RD;
         RD: begin
            if (xfer_done) begin
               rdata_d = reconfig_readdata;
               state_d = WR;
            end
         end
         WR: begin
            if (xfer_done) begin
               if (idx_q == LAST_IDX) begin
                  state_d = CAL_RD;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = RD;
               end
            end
         end
         CAL_RD: begin
            if (xfer_done) begin
               rdata_d = reconfig_readdata;
               state_d = CAL_WR;
            end
         end
         CAL_WR: if (xfer_done) state_d = BUS_REL;
         BUS_REL: begin
            if (xfer_done) begin
               timer_d = '0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            // Timer is not cleared here: the lock timeout covers SETTLE too.
            timer_d = timer_q + TMR_W'(1);
            if (timer_q == SETTLE_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            timer_d = timer_q + TMR_W'(1);
            // Lock wins over timeout on the same cycle so done and error are exclusive.
            if (!pll_cal_busy && pll_locked) begin
               state_d = DONE;
            end else if (timer_q >= TIMEOUT_LAST) begin
               error_d = 1'b1;
               state_d = IDLE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs decoded from the state being entered.
   always_comb begin
      write_d = 1'b0;
      read_d  = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      case (state_d)
         BUS_REQ: begin
            write_d = 1'b1;
            addr_d  = ARB_ADDR;
            wdata_d = ARB_REQ_VAL;
         end
         RD: begin
            read_d = 1'b1;
            addr_d = entry.addr;
         end
         WR: begin
            write_d = 1'b1;
            addr_d  = entry.addr;
            wdata_d = (rdata_d & ~entry.mask) | (entry.value & entry.mask);
         end
         CAL_RD: begin
            read_d = 1'b1;
            addr_d = CAL_ADDR;
         end
         CAL_WR: begin
            write_d = 1'b1;
            addr_d  = CAL_ADDR;
            wdata_d = rdata_d | CAL_BIT_MASK;
         end
         BUS_REL: begin
            write_d = 1'b1;
            addr_d  = ARB_ADDR;
            wdata_d = ARB_REL_VAL;
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge reconfig_clk) begin
      if (reconfig_reset) begin
         state_q <= IDLE;
         prof_q  <= '0;
         idx_q   <= '0;
         rdata_q <= '0;
         timer_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         write_q <= 1'b0;
         read_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         prof_q  <= prof_d;
         idx_q   <= idx_d;
         rdata_q <= rdata_d;
         timer_q <= timer_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
         write_q <= write_d;
         read_q  <= read_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign busy               = busy_q;
   assign done               = done_q;
   assign error              = error_q;
   assign reconfig_write     = write_q;
   assign reconfig_read      = read_q;
   assign reconfig_address   = addr_q;
   assign reconfig_writedata = wdata_q;

endmodule

// File: tb/tb_fpll_reconfig_ctrl.sv
// Directed bench for fpll_reconfig_ctrl with an Avalon-MM slave responder and transfer recorder.
// Latency: n/a.
// Backpressure: responder stretches each transfer by stall_n waitrequest cycles.
`timescale 1ns/1ps
module tb_fpll_reconfig_ctrl;

   localparam int NE = 8;
   localparam int LT = 100;
   localparam int SC = 16;
   localparam int NX = 2 * NE + 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  rate_sel = 2'd0;
   logic        busy, done, error, wr, rd;
   logic [9:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rd_val = 32'h0;
   logic        waitreq = 1'b0;
   logic        cal_busy = 1'b0;
   logic        locked = 1'b0;

   always #5 clk = ~clk;

   fpll_reconfig_ctrl #(
      .NUM_ENTRIES   (NE),
      .LOCK_TIMEOUT  (LT),
      .SETTLE_CYCLES (SC)
   ) dut (
      .reconfig_clk         (clk),
      .reconfig_reset       (rst),
      .start                (start),
      .rate_sel             (rate_sel),
      .busy                 (busy),
      .done                 (done),
      .error                (error),
      .reconfig_write       (wr),
      .reconfig_read        (rd),
      .reconfig_address     (addr),
      .reconfig_writedata   (wdata),
      .reconfig_readdata    (rd_val),
      .reconfig_waitrequest (waitreq),
      .pll_cal_busy         (cal_busy),
      .pll_locked           (locked)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Recorder state
   int          stall_n = 0, stall_cnt = 0;
   logic [9:0]  rec_addr [64];
   logic        rec_wr   [64];
   logic [31:0] rec_dat  [64];
   int          rec_edge [64];
   int          n_rec = 0, n_unstable = 0, n_both = 0;
   logic        hold_wr = 1'b0;
   logic [9:0]  hold_addr = '0;
   logic [31:0] hold_dat = '0;
   int          done_cnt = 0, done_edge = 0, err_rises = 0, err_edge = 0;
   logic        err_prev = 1'b0;
   int          s_edge = 0;

   // Expected transfer list
   logic [9:0]  exp_addr [NX];
   logic        exp_wr   [NX];
   logic [31:0] exp_dat  [NX];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Slave responder: decides waitrequest for the coming edge and logs completions.
   // A transfer completes on the edge after the negedge where waitrequest is driven 0.
   initial forever begin
      @(negedge clk);
      if (rd === 1'b1 && wr === 1'b1) n_both++;
      if (wr === 1'b1 || rd === 1'b1) begin
         if (stall_cnt == 0) begin
            hold_wr = wr; hold_addr = addr; hold_dat = wdata;
         end else if (hold_wr !== wr || hold_addr !== addr || (wr && hold_dat !== wdata)) begin
            n_unstable++;
         end
         if (stall_cnt < stall_n) begin
            waitreq = 1'b1;
            stall_cnt++;
         end else begin
            waitreq   = 1'b0;
            stall_cnt = 0;
            if (n_rec < 64) begin
               rec_addr[n_rec] = addr;
               rec_wr[n_rec]   = wr;
               rec_dat[n_rec]  = wdata;
               rec_edge[n_rec] = cyc + 1;
            end
            n_rec++;
         end
      end else begin
         waitreq   = 1'b0;
         stall_cnt = 0;
      end
      if (done === 1'b1) begin done_cnt++; done_edge = cyc; end
      if (error === 1'b1 && err_prev !== 1'b1) begin err_rises++; err_edge = cyc; end
      err_prev = error;
   end

   task automatic put(input int i, input logic w, input logic [9:0] a, input logic [31:0] d);
      exp_wr[i] = w; exp_addr[i] = a; exp_dat[i] = d;
   endtask

   // Profile 2 (word 0x0F1E2D3C) against readdata 0xFFFFFFFF.
   task automatic load_p2_ones();
      put(0,  1, 10'h000, 32'h0000_0002);
      put(1,  0, 10'h080, 32'h0);  put(2,  1, 10'h080, 32'hFFFF_FFFC);
      put(3,  0, 10'h084, 32'h0);  put(4,  1, 10'h084, 32'hFFFF_FF3F);
      put(5,  0, 10'h088, 32'h0);  put(6,  1, 10'h088, 32'hFFFF_FDFF);
      put(7,  0, 10'h08C, 32'h0);  put(8,  1, 10'h08C, 32'hFFFF_2FFF);
      put(9,  0, 10'h090, 32'h0);  put(10, 1, 10'h090, 32'hFFFE_FFFF);
      put(11, 0, 10'h094, 32'h0);  put(12, 1, 10'h094, 32'hFF1F_FFFF);
      put(13, 0, 10'h098, 32'h0);  put(14, 1, 10'h098, 32'hFFFF_FFFF);
      put(15, 0, 10'h09C, 32'h0);  put(16, 1, 10'h09C, 32'h0FFF_FFFF);
      put(17, 0, 10'h100, 32'h0);  put(18, 1, 10'h100, 32'hFFFF_FFFF);
      put(19, 1, 10'h000, 32'h0000_0001);
   endtask

   // Profile 0 (word 0x13579BDF) against readdata 0x00000000.
   task automatic load_p0_zero();
      put(0,  1, 10'h000, 32'h0000_0002);
      put(1,  0, 10'h040, 32'h0);  put(2,  1, 10'h040, 32'h0000_000F);
      put(3,  0, 10'h044, 32'h0);  put(4,  1, 10'h044, 32'h0000_00D0);
      put(5,  0, 10'h048, 32'h0);  put(6,  1, 10'h048, 32'h0000_0B00);
      put(7,  0, 10'h04C, 32'h0);  put(8,  1, 10'h04C, 32'h0000_9000);
      put(9,  0, 10'h050, 32'h0);  put(10, 1, 10'h050, 32'h0007_0000);
      put(11, 0, 10'h054, 32'h0);  put(12, 1, 10'h054, 32'h0050_0000);
      put(13, 0, 10'h058, 32'h0);  put(14, 1, 10'h058, 32'h0300_0000);
      put(15, 0, 10'h05C, 32'h0);  put(16, 1, 10'h05C, 32'h1000_0000);
      put(17, 0, 10'h100, 32'h0);  put(18, 1, 10'h100, 32'h0000_0002);
      put(19, 1, 10'h000, 32'h0000_0001);
   endtask

   task automatic do_start(input logic [1:0] p);
      @(negedge clk);
      n_rec = 0; n_unstable = 0; n_both = 0; done_cnt = 0; err_rises = 0;
      start = 1'b1; rate_sel = p; s_edge = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (busy === 1'b1 && k < max) begin
         @(negedge clk);
         k++;
      end
      check_eq("wait_idle", 32'(busy), 32'd0);
   endtask

   task automatic check_seq(input string pfx);
      check_eq({pfx, "_count"}, 32'(n_rec), 32'(NX));
      for (int i = 0; i < NX && i < n_rec; i++) begin
         check_eq($sformatf("%s_addr%0d", pfx, i), 32'(rec_addr[i]), 32'(exp_addr[i]));
         check_eq($sformatf("%s_wr%0d", pfx, i), 32'(rec_wr[i]), 32'(exp_wr[i]));
         if (exp_wr[i]) check_eq($sformatf("%s_dat%0d", pfx, i), rec_dat[i], exp_dat[i]);
      end
   endtask

   initial begin
      // 1: reset
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_error", 32'(error), 0);
      check_eq("rst_write", 32'(wr), 0);
      check_eq("rst_read", 32'(rd), 0);
      check_eq("rst_addr", 32'(addr), 0);
      check_eq("rst_wdata", wdata, 0);
      repeat (10) @(negedge clk);
      check_eq("idle_busy", 32'(busy), 0);
      check_eq("idle_write", 32'(wr), 0);

      // 2: profile 2, no waitrequest, lock already present during SETTLE
      locked = 1'b1; cal_busy = 1'b0; rd_val = 32'hFFFF_FFFF; stall_n = 0;
      load_p2_ones();
      do_start(2'd2);
      check_eq("t2_busy_rise", 32'(busy), 1);
      check_eq("t2_first_write", 32'(wr), 1);
      check_eq("t2_first_addr", 32'(addr), 0);
      check_eq("t2_first_data", wdata, 32'h2);
      wait_idle(200);
      check_seq("t2");
      check_eq("t2_first_lat", 32'(rec_edge[0] - s_edge), 1);
      check_eq("t2_span", 32'(rec_edge[NX-1] - rec_edge[0]), 32'(NX - 1));
      check_eq("t2_done_cnt", 32'(done_cnt), 1);
      check_eq("t2_done_lat", 32'(done_edge - rec_edge[NX-1]), 32'(SC + 1));
      check_eq("t2_no_error", 32'(err_rises), 0);
      check_eq("t2_rw_both", 32'(n_both), 0);

      // 3: waitrequest stretch of 3 cycles on every transfer
      stall_n = 3;
      do_start(2'd2);
      wait_idle(400);
      stall_n = 0;
      check_seq("t3");
      check_eq("t3_unstable", 32'(n_unstable), 0);
      check_eq("t3_span", 32'(rec_edge[NX-1] - rec_edge[0]), 32'((NX - 1) * 4));
      check_eq("t3_done_lat", 32'(done_edge - rec_edge[NX-1]), 32'(SC + 1));
      check_eq("t3_done_cnt", 32'(done_cnt), 1);

      // 4: lock timeout
      locked = 1'b0;
      do_start(2'd1);
      wait_idle(400);
      check_eq("t4_err_rises", 32'(err_rises), 1);
      check_eq("t4_err_lat", 32'(err_edge - rec_edge[NX-1]), 32'(LT));
      check_eq("t4_error_held", 32'(error), 1);
      check_eq("t4_no_done", 32'(done_cnt), 0);
      locked = 1'b1;
      do_start(2'd1);
      check_eq("t4_err_cleared", 32'(error), 0);
      wait_idle(200);
      check_eq("t4_rerun_done", 32'(done_cnt), 1);
      check_eq("t4_rerun_error", 32'(error), 0);

      // 5: start while busy is ignored
      rd_val = 32'h0;
      load_p0_zero();
      do_start(2'd0);
      begin
         int k = 0;
         while (!(rd === 1'b1 && n_rec >= 3) && k < 50) begin
            @(negedge clk);
            k++;
         end
      end
      check_eq("t5_in_rd", 32'(rd), 1);
      start = 1'b1; rate_sel = 2'd3;
      @(negedge clk);
      start = 1'b0;
      check_eq("t5_still_busy", 32'(busy), 1);
      wait_idle(200);
      check_seq("t5");
      check_eq("t5_done_cnt", 32'(done_cnt), 1);

      // 6: reset during WR of entry 4
      rd_val = 32'hFFFF_FFFF;
      load_p2_ones();
      do_start(2'd2);
      begin
         int k = 0;
         while (!(wr === 1'b1 && addr === 10'h090) && k < 50) begin
            @(negedge clk);
            k++;
         end
      end
      check_eq("t6_in_wr4", 32'(wr), 1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("t6_write_drop", 32'(wr), 0);
      check_eq("t6_busy_drop", 32'(busy), 0);
      check_eq("t6_addr_zero", 32'(addr), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("t6_stays_idle", 32'(busy), 0);
      do_start(2'd2);
      check_eq("t6_restart_write", 32'(wr), 1);
      check_eq("t6_restart_addr", 32'(addr), 0);
      wait_idle(200);
      check_seq("t6");
      check_eq("t6_done_cnt", 32'(done_cnt), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
